// File: rtl/gate_resp_checker.sv
// Response checker for 2-input gate DUTs: captures each applied a/b vector, waits SETTLE_CYC
// cycles, compares out against op's truth table. Optional macro: GATE_CHK_STOP_ON_ERR_EN.
module gate_resp_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             vec_valid,
  input  logic             vec_last,
  input  logic             a,
  input  logic             b,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [3:0]       first_err,
  output logic [2:0]       fsm_state
);

  // Handshake: a vector is accepted on a rising edge where vec_valid=1 and the FSM is ARMED;
  // there is no ready output, vec_valid in any other state is dropped.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC);

  state_t             state, state_nxt;
  logic [2:0]         op_q, op_q_nxt;
  logic               a_cap, a_cap_nxt, b_cap, b_cap_nxt, last_cap, last_cap_nxt;
  logic [3:0]         settle_cnt, settle_cnt_nxt;
  logic [CNT_W-1:0]   vec_cnt_nxt, err_cnt_nxt;
  logic [3:0]         cov_nxt, first_err_nxt;
  logic               pass_nxt;
  logic               exp_bit, mism, stop;

  function automatic logic gate_exp(input logic [2:0] f, input logic x, input logic y);
    case (f)
      3'd0:    gate_exp = x & y;
      3'd1:    gate_exp = x | y;
      3'd2:    gate_exp = ~(x & y);
      3'd3:    gate_exp = ~(x | y);
      3'd4:    gate_exp = x ^ y;
      3'd5:    gate_exp = ~(x ^ y);
      3'd6:    gate_exp = ~x;
      default: gate_exp = x;
    endcase
  endfunction

  always_comb begin
    state_nxt      = state;
    op_q_nxt       = op_q;
    a_cap_nxt      = a_cap;
    b_cap_nxt      = b_cap;
    last_cap_nxt   = last_cap;
    settle_cnt_nxt = settle_cnt;
    vec_cnt_nxt    = vec_cnt;
    err_cnt_nxt    = err_cnt;
    cov_nxt        = cov;
    first_err_nxt  = first_err;
    pass_nxt       = pass;
    exp_bit        = gate_exp(op_q, a_cap, b_cap);
    mism           = out ^ exp_bit;
    stop           = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_q_nxt      = op;
          vec_cnt_nxt   = '0;
          err_cnt_nxt   = '0;
          cov_nxt       = '0;
          first_err_nxt = '0;
          pass_nxt      = 1'b0;
          state_nxt     = S_ARMED;
        end
      end
      S_ARMED: begin
        if (vec_valid) begin
          a_cap_nxt      = a;
          b_cap_nxt      = b;
          last_cap_nxt   = vec_last;
          settle_cnt_nxt = SETTLE_INIT;
          state_nxt      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Leaving at count 1 puts the CHECK cycle exactly SETTLE_CYC cycles after acceptance.
        if (settle_cnt <= 4'd1) state_nxt = S_CHECK;
        else settle_cnt_nxt = settle_cnt - 4'd1;
      end
      S_CHECK: begin
        if (vec_cnt != CNT_MAX) vec_cnt_nxt = vec_cnt + CNT_W'(1);
        cov_nxt[{a_cap, b_cap}] = 1'b1;
        if (mism) begin
          if (err_cnt != CNT_MAX) err_cnt_nxt = err_cnt + CNT_W'(1);
          if (!first_err[3]) first_err_nxt = {1'b1, a_cap, b_cap, out};
        end
`ifdef GATE_CHK_STOP_ON_ERR_EN
        stop = last_cap | mism;
`else
        stop = last_cap;
`endif
        if (stop) begin
          state_nxt = S_DONE;
          pass_nxt  = (err_cnt_nxt == '0) && (cov_nxt == 4'hF);
        end else begin
          state_nxt = S_ARMED;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_cap      <= 1'b0;
      b_cap      <= 1'b0;
      last_cap   <= 1'b0;
      settle_cnt <= '0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      cov        <= '0;
      first_err  <= '0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_q       <= op_q_nxt;
      a_cap      <= a_cap_nxt;
      b_cap      <= b_cap_nxt;
      last_cap   <= last_cap_nxt;
      settle_cnt <= settle_cnt_nxt;
      vec_cnt    <= vec_cnt_nxt;
      err_cnt    <= err_cnt_nxt;
      cov        <= cov_nxt;
      first_err  <= first_err_nxt;
      pass       <= pass_nxt;
    end
  end

  assign busy      = (state == S_ARMED) || (state == S_SETTLE) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Synthesizable response checker for the gate-level blocks; it is the receiving end of the exhaustive a/b stimulus sequences the gate benches apply.
- Captures each applied input vector, waits a settle interval, samples the gate-under-test output and compares it against the expected truth table of a selected function.
- Accumulates vector count, error count and input-combination coverage, then reports pass/fail.
- Sits beside any 2-input gate DUT, in the bench or as an on-chip self-test monitor.

Parameters:
- SETTLE_CYC, 2: cycles from vector acceptance to output sampling; legal range 1..15.
- CNT_W, 8: width of the vector and error counters; both counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a check session; honoured only in IDLE or DONE.
- op  in  3  expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
- vec_valid  in  1  a/b carry a newly applied vector this cycle.
- vec_last  in  1  qualifies vec_valid; the vector is the final one of the session.
- a  in  1  DUT input a, as applied.
- b  in  1  DUT input b, as applied.
- out  in  1  DUT output under check.
- busy  out  1  high in ARMED, SETTLE and CHECK.
- done  out  1  high in DONE.
- pass  out  1  result; valid only while done=1.
- vec_cnt  out  CNT_W  number of vectors checked.
- err_cnt  out  CNT_W  number of mismatches.
- cov  out  4  bit {a,b} set once that combination has been checked.
- first_err  out  4  {valid,a,b,out} of the first mismatch.

Behaviour:
- Reset (rst=1 at a clock edge, in any state including mid-session):
  - state goes to IDLE.
  - All outputs go to 0: busy, done, pass, vec_cnt, err_cnt, cov, first_err.
  - Capture registers and the settle counter are cleared.
- FSM:
  - IDLE: start=1 latches op into op_q, clears the counters, cov and first_err, and moves to ARMED.
  - ARMED: vec_valid=1 captures a, b and vec_last, loads the settle counter with SETTLE_CYC, and moves to SETTLE.
  - SETTLE: the counter decrements each cycle. When it reaches 1, move to CHECK, so out is sampled exactly SETTLE_CYC cycles after the acceptance edge.
  - CHECK (one cycle):
    - Compare out with exp = f(op_q, a_cap, b_cap).
    - vec_cnt++ and set cov[{a_cap,b_cap}].
    - On mismatch: err_cnt++; if first_err[3]=0, load first_err = {1,a_cap,b_cap,out}.
    - Next state is DONE if the captured last flag is set, otherwise ARMED.
  - DONE: counters hold. start=1 clears them and re-enters ARMED with a newly latched op.
- pass = (err_cnt==0) && (cov==4'hF); it updates on entry to DONE.
- vec_valid outside ARMED is ignored, with no queueing. a/b changes during SETTLE are ignored because the captured values are used.
- start during ARMED, SETTLE or CHECK is ignored.
- op changes mid-session have no effect because op_q is used.
- Counter saturation: at all-ones, vec_cnt and err_cnt hold their value. cov and first_err are still updated.
- Ops 6/7 ignore b for exp, but cov is still indexed by {a,b}.
- Minimum vector spacing is SETTLE_CYC+2 cycles (accept, settle, check). Back-to-back vec_valid is accepted on the cycle after CHECK.

Optional Feature:
- Macro: GATE_CHK_STOP_ON_ERR_EN.
- Defined: the first mismatch forces CHECK -> DONE regardless of the last flag, with pass=0. vec_cnt includes the failing vector.
- Undefined: checking continues to vec_last and all mismatches are counted.

Test Plan:
- SETTLE_CYC=2, op=0 (AND), correct AND DUT, vectors 00, 10, 01, 11 (last on 11):
  - done=1, pass=1, vec_cnt=4, err_cnt=0, cov=4'hF.
  - Each sample occurs 2 cycles after its vec_valid.
- op=1 (OR) with an AND DUT attached, same 4 vectors:
  - err_cnt=2 (vectors 10 and 01), pass=0, first_err=4'b1100.
  - With GATE_CHK_STOP_ON_ERR_EN defined: done after vector 10, vec_cnt=2.
- op=4 (XOR), correct DUT, only vectors 00 and 11:
  - pass=0 because cov=4'b1001, even though err_cnt=0.
- Assert rst during SETTLE of the third vector:
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent start plus 4 vectors gives vec_cnt=4.
- Pulse vec_valid every cycle for 10 cycles with SETTLE_CYC=1:
  - Only vectors presented in ARMED are counted, giving vec_cnt=4 over 10 cycles.
  - a/b toggled during SETTLE do not alter the compared value.
- CNT_W=2, 5 mismatching vectors: err_cnt saturates at 3.
